// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: four 2-entry result FIFOs feeding two register-file write ports.
// Define WB_WAW_SERIALIZE_EN to hold back a port-2 grant whose tag matches port 1.
module wb_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic [3:0]              src_valid_i,
   input  logic [4*TAG_WIDTH-1:0]  src_tag_i,
   input  logic [4*DATA_WIDTH-1:0] src_data_i,
   output logic [3:0]              src_ready_o,
   output logic                    write1_en_o,
   output logic [TAG_WIDTH-1:0]    tag1_o,
   output logic [DATA_WIDTH-1:0]   data1_o,
   output logic                    write2_en_o,
   output logic [TAG_WIDTH-1:0]    tag2_o,
   output logic [DATA_WIDTH-1:0]   data2_o
);
   localparam int EW = TAG_WIDTH + DATA_WIDTH;

   logic [EW-1:0] mem [4][2];
   logic [EW-1:0] head [4];
   logic [1:0]    cnt [4];
   logic [3:0]    rd_ptr, wr_ptr;
   logic [3:0]    nonempty, push, pop;
   logic [1:0]    rr_ptr;
   logic          g1_vld, g2_vld, g2_ok;
   logic [1:0]    g1_src, g2_src, idx;

   always_comb begin
      for (int s = 0; s < 4; s++) begin
         src_ready_o[s] = (cnt[s] != 2'd2);
         nonempty[s]    = (cnt[s] != 2'd0);
         push[s]        = src_valid_i[s] && (cnt[s] != 2'd2);
         head[s]        = mem[s][rd_ptr[s]];
      end
   end

   // Round-robin scan from rr_ptr: first two non-empty heads win.
   always_comb begin
      g1_vld = 1'b0;
      g2_vld = 1'b0;
      g1_src = 2'd0;
      g2_src = 2'd0;
      idx    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (nonempty[idx]) begin
            if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_src = idx;
            end else if (!g2_vld) begin
               g2_vld = 1'b1;
               g2_src = idx;
            end
         end
      end
   end

`ifdef WB_WAW_SERIALIZE_EN
   assign g2_ok = g2_vld &&
      (head[g1_src][EW-1 -: TAG_WIDTH] != head[g2_src][EW-1 -: TAG_WIDTH]);
`else
   assign g2_ok = g2_vld;
`endif

   always_comb begin
      for (int s = 0; s < 4; s++)
         pop[s] = (g1_vld && g1_src == 2'(s)) || (g2_ok && g2_src == 2'(s));
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < 4; s++)
         if (push[s] && !flush_i)
            mem[s][wr_ptr[s]] <= {src_tag_i[s*TAG_WIDTH +: TAG_WIDTH],
                                  src_data_i[s*DATA_WIDTH +: DATA_WIDTH]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 4; s++) cnt[s] <= 2'd0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rr_ptr      <= 2'd0;
         write1_en_o <= 1'b0;
         tag1_o      <= '0;
         data1_o     <= '0;
         write2_en_o <= 1'b0;
         tag2_o      <= '0;
         data2_o     <= '0;
      end else if (flush_i) begin
         for (int s = 0; s < 4; s++) cnt[s] <= 2'd0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rr_ptr      <= 2'd0;
         write1_en_o <= 1'b0;
         tag1_o      <= '0;
         data1_o     <= '0;
         write2_en_o <= 1'b0;
         tag2_o      <= '0;
         data2_o     <= '0;
      end else begin
         for (int s = 0; s < 4; s++) begin
            if (push[s]) wr_ptr[s] <= ~wr_ptr[s];
            if (pop[s])  rd_ptr[s] <= ~rd_ptr[s];
            cnt[s] <= cnt[s] + {1'b0, push[s]} - {1'b0, pop[s]};
         end
         if (g1_vld)
            rr_ptr <= (g2_ok ? g2_src : g1_src) + 2'd1;
         write1_en_o <= g1_vld;
         tag1_o      <= g1_vld ? head[g1_src][EW-1 -: TAG_WIDTH] : '0;
         data1_o     <= g1_vld ? head[g1_src][DATA_WIDTH-1:0] : '0;
         write2_en_o <= g2_ok;
         tag2_o      <= g2_ok ? head[g2_src][EW-1 -: TAG_WIDTH] : '0;
         data2_o     <= g2_ok ? head[g2_src][DATA_WIDTH-1:0] : '0;
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_write_arbiter;
   localparam int DW = 32;
   localparam int TW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [3:0]      src_valid;
   logic [4*TW-1:0] src_tag;
   logic [4*DW-1:0] src_data;
   logic [3:0]      src_ready;
   logic            en1, en2;
   logic [TW-1:0]   tag1, tag2;
   logic [DW-1:0]   data1, data2;

   int tests = 0;
   int fails = 0;
   int out_cnt = 0;

   wb_write_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk(clk),
      .rst(rst),
      .flush_i(flush),
      .src_valid_i(src_valid),
      .src_tag_i(src_tag),
      .src_data_i(src_data),
      .src_ready_o(src_ready),
      .write1_en_o(en1),
      .tag1_o(tag1),
      .data1_o(data1),
      .write2_en_o(en2),
      .tag2_o(tag2),
      .data2_o(data2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: per-source queues and an integer round-robin pointer.
   logic [TW+DW-1:0] mq [4][$];
   logic [TW+DW-1:0] h;
   int               mrr, g1, g2, ms;
   logic [3:0]       mrdy, mr;
   logic             m_en1, m_en2;
   logic [TW-1:0]    m_tag1, m_tag2;
   logic [DW-1:0]    m_data1, m_data2;

   always @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         for (int s = 0; s < 4; s++) mq[s].delete();
         mrr = 0;
         m_en1 = 0; m_tag1 = '0; m_data1 = '0;
         m_en2 = 0; m_tag2 = '0; m_data2 = '0;
      end else begin
         for (int s = 0; s < 4; s++) mrdy[s] = (mq[s].size() < 2);
         g1 = -1;
         g2 = -1;
         for (int i = 0; i < 4; i++) begin
            ms = (mrr + i) % 4;
            if (mq[ms].size() > 0) begin
               if (g1 < 0) g1 = ms;
               else if (g2 < 0) g2 = ms;
            end
         end
`ifdef WB_WAW_SERIALIZE_EN
         if (g1 >= 0 && g2 >= 0 && mq[g1][0][DW +: TW] == mq[g2][0][DW +: TW])
            g2 = -1;
`endif
         m_en1 = 0; m_tag1 = '0; m_data1 = '0;
         m_en2 = 0; m_tag2 = '0; m_data2 = '0;
         if (g1 >= 0) begin
            h = mq[g1].pop_front();
            m_en1 = 1; m_tag1 = h[DW +: TW]; m_data1 = h[DW-1:0];
            mrr = (g1 + 1) % 4;
         end
         if (g2 >= 0) begin
            h = mq[g2].pop_front();
            m_en2 = 1; m_tag2 = h[DW +: TW]; m_data2 = h[DW-1:0];
            mrr = (g2 + 1) % 4;
         end
         for (int s = 0; s < 4; s++)
            if (src_valid[s] && mrdy[s])
               mq[s].push_back({src_tag[s*TW +: TW], src_data[s*DW +: DW]});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk("en1", en1, m_en1);
         chk("tag1", tag1, m_tag1);
         chk("data1", data1, m_data1);
         chk("en2", en2, m_en2);
         chk("tag2", tag2, m_tag2);
         chk("data2", data2, m_data2);
         for (int s = 0; s < 4; s++) mr[s] = (mq[s].size() < 2);
         chk("ready", src_ready, mr);
         out_cnt += int'(en1) + int'(en2);
`ifdef WB_WAW_SERIALIZE_EN
         if (en1 && en2) chk("waw_same_tag", tag1 == tag2, 0);
`endif
      end
   end

   task automatic set_src(input int s, input logic [TW-1:0] t,
                          input logic [DW-1:0] d);
      src_valid[s] = 1'b1;
      src_tag[s*TW +: TW] = t;
      src_data[s*DW +: DW] = d;
   endtask

   task automatic do_flush();
      @(negedge clk);
      src_valid = '0;
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
   endtask

   int acc [4];
   int base, total;
   logic saw;
   logic [3:0] rdy;

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      src_valid = '0;
      src_tag = '0;
      src_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Reset mid-traffic with FIFOs non-empty
      @(negedge clk);
      for (int s = 0; s < 4; s++) set_src(s, 6'(20 + s), 32'(s));
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_en1", en1, 0);
      chk("rst_en2", en2, 0);
      chk("rst_tag1", tag1, 0);
      chk("rst_data2", data2, 0);
      chk("rst_ready", src_ready, 4'b1111);
      @(negedge clk);
      rst = 1'b1;
      set_src(2, 6'd5, 32'hAA);
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("first_en1", en1, 1);
      chk("first_tag1", tag1, 5);
      chk("first_data1", data1, 32'hAA);
      chk("first_en2", en2, 0);

      // All four push together from rr_ptr=0
      do_flush();
      for (int s = 0; s < 4; s++) set_src(s, 6'(1 + s), 32'h100 + 32'(s));
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("all4_c1_tag1", tag1, 1);
      chk("all4_c1_data2", data2, 32'h101);
      @(posedge clk);
      #1;
      chk("all4_c2_tag1", tag1, 3);
      chk("all4_c2_tag2", tag2, 4);
      @(posedge clk);
      #1;
      chk("all4_c3_en", {en1, en2}, 2'b00);
      @(negedge clk);
      set_src(3, 6'd8, 32'h8);
      set_src(0, 6'd7, 32'h7);
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("rr0_tag1", tag1, 7);
      chk("rr0_tag2", tag2, 8);

      // Single source stream of three results
      @(negedge clk);
      set_src(1, 6'd10, 32'hA0);
      @(posedge clk);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         chk("stream_ready", src_ready[1], 1);
         set_src(1, 6'(10 + i), 32'hA0 + 32'(i));
         @(posedge clk);
         #1;
         chk("stream_tag1", tag1, 64'(10 + i - 1));
         chk("stream_en2", en2, 0);
      end
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("stream_last", data1, 32'hA2);
      @(posedge clk);
      #1;
      chk("stream_idle", en1, 0);

      // Backpressure with all four sources busy
      for (int s = 0; s < 4; s++) acc[s] = 0;
      saw = 1'b0;
      @(negedge clk);
      base = out_cnt;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         rdy = src_ready;
         if (!rdy[1]) saw = 1'b1;
         for (int s = 0; s < 4; s++)
            set_src(s, 6'(s * 8 + acc[s] % 8), 32'h1000 * 32'(s) + 32'(acc[s]));
         @(posedge clk);
         for (int s = 0; s < 4; s++) if (rdy[s]) acc[s]++;
      end
      @(negedge clk);
      src_valid = '0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      total = acc[0] + acc[1] + acc[2] + acc[3];
      chk("bp_ready1_dropped", saw, 1);
      chk("bp_all_out_once", out_cnt - base, total);

      // Flush with five entries buffered and a push in flight
      @(negedge clk);
      for (int s = 0; s < 4; s++) set_src(s, 6'(40 + s), 32'hF0 + 32'(s));
      @(posedge clk);
      @(negedge clk);
      src_valid = 4'b0000;
      for (int s = 0; s < 3; s++) set_src(s, 6'(44 + s), 32'hF4 + 32'(s));
      @(posedge clk);
      @(negedge clk);
      src_valid = 4'b0000;
      set_src(3, 6'd50, 32'hF8);
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_en", {en1, en2}, 2'b00);
      chk("flush_ready", src_ready, 4'b1111);
      base = out_cnt;
      @(negedge clk);
      flush = 1'b0;
      src_valid = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("flush_no_leak", out_cnt - base, 0);

      // Same-tag heads on src0 and src1
      do_flush();
      set_src(0, 6'd9, 32'h11);
      set_src(1, 6'd9, 32'h22);
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      @(posedge clk);
      #1;
      chk("waw_c1_data1", data1, 32'h11);
`ifdef WB_WAW_SERIALIZE_EN
      chk("waw_c1_en2", en2, 0);
      @(posedge clk);
      #1;
      chk("waw_c2_en1", en1, 1);
      chk("waw_c2_data1", data1, 32'h22);
`else
      chk("waw_c1_en2", en2, 1);
      chk("waw_c1_tag2", tag2, 9);
      chk("waw_c1_data2", data2, 32'h22);
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that collects completed results from four functional-unit pipes and drives the two synchronous write ports of the register file. Each source hands off a (tag, data) result over a valid/ready handshake into a private 2-entry FIFO. Each cycle a round-robin arbiter grants up to two FIFO heads, one per write port, and the block registers them onto the write-port outputs. It sits between the execution pipes and the register file, on the write side.

## Interface
- DATA_WIDTH, 32, result data width
- TAG_WIDTH, 6, destination physical register tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; clears FIFOs and write outputs
- src_valid_i  in  4  per-source result valid
- src_tag_i  in  4*TAG_WIDTH  per-source tag; source s at bits [s*TAG_WIDTH +: TAG_WIDTH]
- src_data_i  in  4*DATA_WIDTH  per-source data; same packing
- src_ready_o  out  4  per-source ready; high when that FIFO holds fewer than 2 entries
- write1_en_o  out  1  port-1 write enable
- tag1_o  out  TAG_WIDTH  port-1 tag
- data1_o  out  DATA_WIDTH  port-1 data
- write2_en_o  out  1  port-2 write enable
- tag2_o  out  TAG_WIDTH  port-2 tag
- data2_o  out  DATA_WIDTH  port-2 data

## Operation
- Reset (rst low, asynchronous): all FIFOs empty, rr_ptr=0, write1_en_o=write2_en_o=0, tag/data outputs 0, src_ready_o=4'b1111.
- Accept: src_valid_i[s] && src_ready_o[s] at an edge pushes {tag, data} into FIFO s. src_ready_o depends only on the registered count, so a full FIFO stays not-ready in a cycle when it pops.
- Arbitration is combinational on the FIFO heads. Scan sources rr_ptr, rr_ptr+1, ... (mod 4). The first non-empty source gets port 1. The next non-empty source gets port 2.
- On the edge, granted heads pop. The outputs register the grants: write1_en_o is set iff port 1 was granted, and likewise for port 2. An ungranted port drives en=0 with tag/data 0.
- rr_ptr update: becomes (last granted source + 1) mod 4. Unchanged if nothing is granted.
- Only one entry per FIFO can be granted per cycle.
- Within one source, results leave in FIFO order.
- flush_i: at the edge, empty all FIFOs and clear both write enables. Pushes in the same cycle are discarded. rr_ptr resets to 0. Flush overrides pushes and grants.

## Timing
- A result accepted at edge k is eligible at edge k+1. At the earliest, it appears on the write port after edge k+1; the register file commits it at edge k+2.
- Sustained throughput is 2 results/cycle. A single source sustains 1 result/cycle.
- With all four sources continuously busy, each source is granted at least every 2 cycles (starvation-free).
- Outputs are fully registered and have no combinational path from src_*_i.
- src_ready_o is registered-state-derived and has no combinational path from src_valid_i.

## Configuration
- WB_WAW_SERIALIZE_EN defined: if both selected heads carry equal tags, only the port-1 grant issues. The second source keeps its entry, and rr_ptr advances past the port-1 source only. The second entry issues in a later cycle, so a port never sees the same tag as the other port in the same cycle.
- Undefined: both grants issue regardless of tag equality, and the register file's port-1 priority resolves the collision. Verification must flag same-tag dual writes only when the macro is defined.

## Test plan
- Reset: hold rst low mid-traffic with FIFOs non-empty -> immediately en=0, outputs 0, src_ready_o=4'b1111. After release, the first push on src 2 (tag 5, data 0xAA) yields write1_en_o=1, tag1_o=5, data1_o=0xAA two edges later.
- All four sources push one result at the same edge, rr_ptr=0 -> next cycle ports carry src0/src1, the following cycle src2/src3, then enables drop. rr_ptr ends at 0.
- Single source streams 3 results with valid held high -> ready drops only when count=2. Results emerge on port 1 in order, one per cycle, and port 2 stays idle.
- Backpressure: fill FIFO 1 (2 entries) while higher-priority traffic competes -> src_ready_o[1]=0. No entry is lost or duplicated, and every result appears exactly once.
- flush_i asserted with 5 entries buffered and a push in flight -> next cycle both en=0, all ready=1, and no flushed result ever appears on the ports.
- Src0 and src1 both carry tag 9 (data 0x11, 0x22) -> with WB_WAW_SERIALIZE_EN, port 1 writes 0x11 in one cycle and 0x22 issues in a later cycle. Without the macro, port 1=0x11 and port 2=0x22 in the same cycle.
